// File: rtl/ysyx_23060077_div_iter.sv
// ysyx_23060077_div_iter: WIDTH-generic restoring radix-2 divider, signed/unsigned, RISC-V special results.
// Define YSYX_23060077_DIV_FAST_SPECIAL_EN to resolve divide-by-zero and signed overflow in one cycle.
module ysyx_23060077_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             div_valid,
    output logic             div_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, quo, dvs, dvd;
    logic             neg_q, neg_r, dz, ovf;
    logic [WIDTH-1:0] a_mag, b_mag, rem_n, quo_n, q_fix, r_fix;
    logic [WIDTH:0]   shifted, diff;
    logic             in_dz, in_ovf, ge;
    assign div_ready = (state == IDLE);
    assign out_valid = (state == DONE);
    assign a_mag   = (div_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign b_mag   = (div_signed && divisor[WIDTH-1]) ? -divisor : divisor;
    assign in_dz   = (divisor == '0);
    assign in_ovf  = div_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
    // Partial remainder stays below the divisor, so a non-negative difference fits in WIDTH bits.
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs};
    assign ge      = !diff[WIDTH];
    assign rem_n   = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_n   = {quo[WIDTH-2:0], ge};
    assign q_fix   = dz ? '1 : ovf ? dvd : neg_q ? -quo_n : quo_n;
    assign r_fix   = dz ? dvd : ovf ? '0 : neg_r ? -rem_n : rem_n;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            dvd       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dz        <= 1'b0;
            ovf       <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (div_valid) begin
                    dvd   <= dividend;
                    neg_q <= div_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_r <= div_signed && dividend[WIDTH-1];
                    dz    <= in_dz;
                    ovf   <= in_ovf;
                    rem   <= '0;
                    quo   <= a_mag;
                    dvs   <= b_mag;
`ifdef YSYX_23060077_DIV_FAST_SPECIAL_EN
                    if (in_dz || in_ovf) begin
                        state     <= DONE;
                        cnt       <= '0;
                        quotient  <= in_dz ? '1 : dividend;
                        remainder <= in_dz ? dividend : '0;
                    end else begin
                        state <= BUSY;
                        cnt   <= CW'(WIDTH);
                    end
`else
                    state <= BUSY;
                    cnt   <= CW'(WIDTH);
`endif
                end
                BUSY: begin
                    rem <= rem_n;
                    quo <= quo_n;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        quotient  <= q_fix;
                        remainder <= r_fix;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
